cpu_mem_model: RTL and testbench
================================

// Module: cpu_mem_model
// PURPOSE
//  Parametrised single-port word memory on the CPU bus (addr/data-in/data-out/read/write).
//  Adds configurable wait states and a ready handshake in place of zero-latency combinational
//  memory, so CPU stall logic can be exercised. Holds both instruction and data words.
//  Instantiated beside CPU in benches and FPGA builds.
// PARAMETERS
//  DATA_W       32        data word width (multiple of 8)
//  ADDR_W       32        byte-address width
//  DEPTH        1024      number of DATA_W words
//  BASE_ADDR    32'h0     byte address of word 0
//  WAIT_STATES  0         extra cycles before oReady (0..15)
//  INIT_FILE    ""        hex image loaded by $readmemh at time 0; "" = all zeros
// PORTS
//  iClk        in   1        clock, rising edge
//  nRst        in   1        asynchronous active-low reset
//  iAddr       in   ADDR_W   byte address of request
//  iData       in   DATA_W   write data
//  iRead       in   1        read request
//  iWrite      in   1        write request
//  oData       out  DATA_W   read data, valid only while oReady=1
//  oReady      out  1        access complete, one-cycle pulse
//  oBusy       out  1        request accepted, not yet complete
//  oFault      out  1        (MEM_FAULT_CHECK_EN only) fault on completed access
// BEHAVIOUR
//  - Reset (nRst=0, async): state=IDLE, oData=0, oReady=0, oBusy=0, oFault=0, wait counter=0.
//    Array contents are NOT cleared. Reset mid-access aborts it; a pending write is not committed.
//  - FSM IDLE -> WAIT -> DONE -> IDLE.
//    IDLE: on rising edge with iRead|iWrite=1, latch iAddr, iData, op; go WAIT if WAIT_STATES>0
//      (counter=WAIT_STATES-1), else DONE. oBusy=1 from the following cycle.
//    WAIT: decrement counter each cycle; at 0 go DONE. iAddr/iData/iRead/iWrite ignored.
//    DONE: oReady=1 for exactly one cycle; write commits at the edge entering DONE; read data on
//      oData from latched address. Next state IDLE; oBusy=0.
//  - Latency: request sampled at edge N -> oReady high in cycle N+1+WAIT_STATES.
//  - Minimum one IDLE cycle between accesses: a request held high through DONE is re-sampled
//    in IDLE as a new access (master deasserts on oReady to avoid a repeat).
//  - iRead and iWrite both 1: treated as write (write priority).
//  - Word index = (latched addr - BASE_ADDR) >> log2(DATA_W/8), unsigned modulo 2^ADDR_W.
//  - Out-of-range (index >= DEPTH, including addr < BASE_ADDR wrap) or misaligned (low byte bits
//    nonzero): read returns 0, write dropped; oReady still pulses (no bus hang).
//  - Read-after-write to same word in back-to-back accesses returns the new value.
//  - oData=0 whenever oReady=0.
// CONFIGURATION
//  MEM_FAULT_CHECK_EN defined: oFault port present; asserted with oReady for out-of-range,
//    misaligned, or simultaneous read+write accesses; 0 otherwise; reset 0.
//  Not defined: oFault port absent; identical silent handling (read 0 / write dropped).
// TESTING
//  1. WAIT_STATES=0, image word[0]=32'h1234_5678; read 0x0 -> oReady one cycle later,
//     oData=32'h1234_5678, oBusy low throughout the pulse.
//  2. WAIT_STATES=3; write 32'hDEAD_BEEF to 0x1000 then read 0x1000 -> each oReady exactly 4
//     cycles after request edge; read returns 32'hDEAD_BEEF.
//  3. Read 0x1002 (misaligned) and 0x1_0000 (DEPTH=1024) -> oData=0, oReady pulses;
//     with MEM_FAULT_CHECK_EN oFault=1 on both; write to 0x1_0000 leaves all words unchanged.
//  4. iRead=iWrite=1, addr 0x8, data 32'h5 -> word[2]=5; fault flagged if macro on.
//  5. WAIT_STATES=5; write 32'hAA to 0x4, nRst low in 2nd WAIT cycle -> outputs 0 immediately;
//     after release read 0x4 returns prior value (not 32'hAA).
//  6. Hold iRead high across 3 accesses, WAIT_STATES=1 -> oReady pulses every 3 cycles,
//     one IDLE cycle between, same data each time.

Source files
------------

// File: rtl/cpu_mem_model.sv
// cpu_mem_model: single-port word memory with programmable wait states and a one-cycle ready pulse.
// Define MEM_FAULT_CHECK_EN to add oFault (out-of-range, misaligned or read+write access).
module cpu_mem_model #(
  parameter int                 DATA_W      = 32,
  parameter int                 ADDR_W      = 32,
  parameter int                 DEPTH       = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int                 WAIT_STATES = 0,
  parameter string              INIT_FILE   = ""
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iData,
  input  logic              iRead,
  input  logic              iWrite,
  output logic [DATA_W-1:0] oData,
  output logic              oReady,
  output logic              oBusy
`ifdef MEM_FAULT_CHECK_EN
  ,
  output logic              oFault
`endif
);
  localparam int LSB   = $clog2(DATA_W / 8);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_e, off;
  logic [DATA_W-1:0] data_q, data_e, rdata_q;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        cnt_q;
  logic              wr_q, wr_e, req, to_done, bad_align, in_range, ok;
  logic              ready_q, busy_q;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_FAULT_CHECK_EN
  logic              both_q, both_e, fault_q;
  assign both_e = state_q == IDLE ? iRead & iWrite : both_q;
  assign oFault = fault_q;
`endif
  assign req    = iRead | iWrite;
  assign oData  = rdata_q;
  assign oReady = ready_q;
  assign oBusy  = busy_q;
  // In IDLE the live bus is decoded so a zero-wait access completes on its sampling edge.
  always_comb begin
    addr_e    = state_q == IDLE ? iAddr : addr_q;
    data_e    = state_q == IDLE ? iData : data_q;
    wr_e      = state_q == IDLE ? iWrite : wr_q;
    off       = addr_e - BASE_ADDR;
    bad_align = |(addr_e & ADDR_W'(DATA_W / 8 - 1));
    in_range  = (off >> LSB) < ADDR_W'(DEPTH);
    ok        = in_range && !bad_align;
    idx       = IDX_W'(off >> LSB);
    to_done   = state_q == IDLE ? req && WAIT_STATES == 0 : state_q == WAIT && cnt_q == 4'd0;
    state_d   = state_q == IDLE ? (req ? (WAIT_STATES == 0 ? DONE : WAIT) : IDLE) :
                state_q == WAIT ? (cnt_q == 4'd0 ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_FAULT_CHECK_EN
      both_q  <= 1'b0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q <= iAddr;
        data_q <= iData;
        wr_q   <= iWrite;
        cnt_q  <= 4'(WAIT_STATES - 1);
`ifdef MEM_FAULT_CHECK_EN
        both_q <= iRead & iWrite;
`endif
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      ready_q <= to_done;
      busy_q  <= state_d == WAIT;
      rdata_q <= to_done && !wr_e && ok ? mem[idx] : '0;
`ifdef MEM_FAULT_CHECK_EN
      fault_q <= to_done && (!ok || both_e);
`endif
    end
  end
  // Bad accesses still complete on the bus but never touch the array.
  always_ff @(posedge iClk) begin
    if (to_done && wr_e && ok) mem[idx] <= data_e;
  end
endmodule

// File: tb/tb_cpu_mem_model.sv
// tb_cpu_mem_model: four memories with different wait states driven by directed accesses,
// checked by a scoreboard monitor on every ready pulse.
module tb_cpu_mem_model;
  logic clk = 1'b0;
  logic nRst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] addr [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        rd [4];
  logic        wr [4];
  logic        rdy [4];
  logic        busy [4];
`ifdef MEM_FAULT_CHECK_EN
  logic        fault [4];
`endif
  for (genvar g = 0; g < 4; g++) begin : g_dut
    cpu_mem_model #(
      .DEPTH(g == 1 ? 2048 : 1024),
      .WAIT_STATES(g == 0 ? 0 : g == 1 ? 3 : g == 2 ? 5 : 1)
    ) u_dut (
      .iClk(clk), .nRst(nRst), .iAddr(addr[g]), .iData(wdata[g]),
      .iRead(rd[g]), .iWrite(wr[g]), .oData(rdata[g]), .oReady(rdy[g]), .oBusy(busy[g])
`ifdef MEM_FAULT_CHECK_EN
      , .oFault(fault[g])
`endif
    );
  end
  function automatic int ws(int i);
    return i == 0 ? 0 : i == 1 ? 3 : i == 2 ? 5 : 1;
  endfunction
  typedef struct {int inst; logic [31:0] data; int cyc; bit chk_data; bit fault;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (nRst) begin
      for (int i = 0; i < 4; i++) begin
        if (rdy[i] === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: inst %0d pulsed with empty scoreboard", i);
          end else begin
            mon_e = sb.pop_front();
            chk("ready_inst", i, mon_e.inst);
            chk("ready_cycle", cyc, mon_e.cyc);
            chk("busy_at_ready", busy[i], 0);
            if (mon_e.chk_data) chk("read_data", rdata[i], mon_e.data);
`ifdef MEM_FAULT_CHECK_EN
            chk("fault", fault[i], mon_e.fault);
`endif
          end
        end else begin
          chk("data_zero_idle", rdata[i], 0);
        end
      end
    end
  end
  task automatic wait_ready(int i);
    int k = 0;
    while (rdy[i] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rdy[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: inst %0d got no ready within 40 cycles", i);
    end
  endtask
  task automatic access(int i, bit r, bit w, logic [31:0] a, logic [31:0] d, logic [31:0] ed, bit ef);
    @(negedge clk);
    rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
    sb.push_back('{i, ed, cyc + 1 + ws(i), r && !w, ef});
    @(negedge clk);
    rd[i] = 1'b0; wr[i] = 1'b0;
    chk("busy_after_accept", busy[i], ws(i) > 0);
    wait_ready(i);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_ready", rdy[i], 0);
      chk("reset_busy", busy[i], 0);
      chk("reset_data", rdata[i], 0);
    end
    nRst = 1'b1;
    access(0, 0, 1, 32'h0,     32'h1234_5678, 0, 0);
    access(0, 1, 0, 32'h0,     0, 32'h1234_5678, 0);
    access(0, 0, 1, 32'hFFC,   32'hCAFE_0001, 0, 0);
    access(0, 1, 0, 32'hFFC,   0, 32'hCAFE_0001, 0);
    access(0, 1, 0, 32'h2,     0, 0, 1);
    access(0, 1, 0, 32'h1002,  0, 0, 1);
    access(0, 1, 0, 32'h1000,  0, 0, 1);
    access(0, 1, 0, 32'h1_0000, 0, 0, 1);
    access(0, 0, 1, 32'h1_0000, 32'hFFFF_FFFF, 0, 1);
    access(0, 0, 1, 32'h1000,  32'hFFFF_FFFF, 0, 1);
    access(0, 1, 0, 32'h0,     0, 32'h1234_5678, 0);
    access(0, 1, 0, 32'hFFC,   0, 32'hCAFE_0001, 0);
    access(0, 1, 1, 32'h8,     32'h5, 0, 1);
    access(0, 1, 0, 32'h8,     0, 32'h5, 0);
    access(1, 0, 1, 32'h1000,  32'hDEAD_BEEF, 0, 0);
    access(1, 1, 0, 32'h1000,  0, 32'hDEAD_BEEF, 0);
    access(1, 1, 0, 32'h1002,  0, 0, 1);
    access(2, 0, 1, 32'h4,     32'h11, 0, 0);
    @(negedge clk);
    wr[2] = 1'b1; addr[2] = 32'h4; wdata[2] = 32'hAA;
    @(negedge clk);
    wr[2] = 1'b0;
    chk("busy_in_wait", busy[2], 1);
    @(negedge clk);
    #1 nRst = 1'b0;
    #1;
    chk("abort_ready", rdy[2], 0);
    chk("abort_busy", busy[2], 0);
    chk("abort_data", rdata[2], 0);
    @(negedge clk);
    nRst = 1'b1;
    access(2, 1, 0, 32'h4, 0, 32'h11, 0);
    access(3, 0, 1, 32'h10, 32'h77, 0, 0);
    @(negedge clk);
    rd[3] = 1'b1; addr[3] = 32'h10;
    for (int k = 0; k < 3; k++) sb.push_back('{3, 32'h77, cyc + 2 + 3 * k, 1'b1, 1'b0});
    repeat (3) begin
      @(negedge clk);
      wait_ready(3);
    end
    rd[3] = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected responses never arrived", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
